// File: rtl/video_stream_pkg.sv
// Shared types and constants for the classic-to-AXIS video framer.
// Holds the FSM state encoding, default geometry widths and the layout of
// one skid-buffer entry {tdata, tuser, tlast}.
package video_stream_pkg;

    // Default pixel and geometry widths used by the top-level parameters.
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_COL_BITS = 12;
    localparam int DEF_ROW_BITS = 12;

    // Number of sideband bits carried next to each pixel (tuser, tlast).
    localparam int META_BITS = 2;

    // Framer control states.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // One buffered beat at the default pixel width. The top packs entries
    // in the same order, {tdata, tuser, tlast}, at its configured width.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] tdata;
        logic                 tuser;
        logic                 tlast;
    } skid_entry_t;

    // Width of a packed skid entry for a given pixel width.
    function automatic int entry_width(input int data_w);
        return data_w + META_BITS;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry output stage: an output register plus one skid register.
//
// Handshake: an input beat moves when in_valid && in_ready at a rising edge;
// an output beat moves when out_valid && out_ready at a rising edge. in_ready
// is registered and is only high when the skid register will be empty, so an
// accepted beat always has a free slot even if the output stalls that cycle.
// out_data holds stable while out_valid && !out_ready, and out_valid only
// falls after a completed output beat (or on reset / clear).
module axis_skid_buffer #(
    parameter int PAYLOAD_W = 34
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 allow,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 out_ready
);

    logic                 skid_valid;
    logic [PAYLOAD_W-1:0] skid_data;

    logic                 in_fire;
    logic                 out_fire;
    logic                 out_valid_n;
    logic [PAYLOAD_W-1:0] out_data_n;
    logic                 skid_valid_n;
    logic [PAYLOAD_W-1:0] skid_data_n;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Next-state of both slots: refill the output register from skid first,
    // then from the input; park the input in skid only when output is stalled.
    always_comb begin
        out_valid_n  = out_valid;
        out_data_n   = out_data;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        if (out_fire || !out_valid) begin
            if (skid_valid) begin
                out_valid_n  = 1'b1;
                out_data_n   = skid_data;
                skid_valid_n = 1'b0;
            end else if (in_fire) begin
                out_valid_n = 1'b1;
                out_data_n  = in_data;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
        end
    end

    // Slot registers and the registered ready; clear drops everything held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else if (clear) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            in_ready   <= allow && !skid_valid_n;
        end
    end

endmodule

// File: rtl/classic_to_axis_video.sv
// Classic src_rdy/dst_rdy pixel stream to AXI4-Stream video.
// Counts columns and rows against a geometry latched while idle, tags each
// accepted pixel with tuser (first pixel of frame) and tlast (last pixel of
// line) and sends it out through a registered two-entry skid buffer.
//
// Optional feature macro: VIDEO_FRAMER_STATS_EN adds frame_count and
// line_count outputs. With it undefined neither port nor its logic exists.
//
// Input beat: src_rdy_i && dst_rdy_o at a rising edge.
// Output beat: m_tvalid && m_tready at a rising edge.
module classic_to_axis_video
    import video_stream_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int COL_BITS = DEF_COL_BITS,
    parameter int ROW_BITS = DEF_ROW_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic [WIDTH-1:0]    datain,
    input  logic                src_rdy_i,
    output logic                dst_rdy_o,
    output logic [WIDTH-1:0]    m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tuser,
    output logic                m_tlast,
    input  logic [COL_BITS-1:0] cfg_cols,
    input  logic [ROW_BITS-1:0] cfg_rows,
    output logic                frame_done,
    output logic                busy,
    output logic                dbg_state
`ifdef VIDEO_FRAMER_STATS_EN
    ,
    output logic [15:0]         frame_count,
    output logic [ROW_BITS-1:0] line_count
`endif
);

    localparam int PAYLOAD_W = entry_width(WIDTH);

    state_t              state;
    logic [COL_BITS-1:0] cols_q;
    logic [ROW_BITS-1:0] rows_q;
    logic [COL_BITS-1:0] col_q;
    logic [ROW_BITS-1:0] row_q;

    logic                in_fire;
    logic                sof;
    logic                eol;
    logic                last_row;
    logic                frame_end;
    logic                geom_ok;
    logic                run_next;
    logic [PAYLOAD_W-1:0] in_entry;
    logic [PAYLOAD_W-1:0] out_entry;

    assign in_fire = src_rdy_i && dst_rdy_o;

    // Position tags; the minus-one compares stay at counter width so an
    // all-ones geometry is handled without widening.
    assign sof      = (row_q == '0) && (col_q == '0);
    assign eol      = (col_q == (cols_q - COL_BITS'(1)));
    assign last_row = (row_q == (rows_q - ROW_BITS'(1)));
    assign frame_end = in_fire && (state == S_RUN) && eol && last_row;

    // Start a frame only when both the value being latched and the value
    // already held are nonzero; this keeps a one-cycle frame gap while never
    // starting with a zero geometry.
    assign geom_ok = (cfg_cols != '0) && (cfg_rows != '0) &&
                     (cols_q != '0) && (rows_q != '0);

    // Whether the FSM will be in S_RUN next cycle; feeds the registered ready.
    always_comb begin
        run_next = 1'b0;
        if (!clear) begin
            case (state)
                S_IDLE:  run_next = geom_ok;
                S_RUN:   run_next = !frame_end;
                default: run_next = 1'b0;
            endcase
        end
    end

    // Framer FSM with column/row counters and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cols_q     <= '0;
            rows_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else if (clear) begin
            state      <= S_IDLE;
            cols_q     <= '0;
            rows_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= frame_end;
            busy       <= run_next;
            case (state)
                S_IDLE: begin
                    cols_q <= cfg_cols;
                    rows_q <= cfg_rows;
                    col_q  <= '0;
                    row_q  <= '0;
                    if (geom_ok) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (in_fire) begin
                        if (eol) begin
                            col_q <= '0;
                            if (last_row) begin
                                row_q <= '0;
                                state <= S_IDLE;
                            end else begin
                                row_q <= row_q + ROW_BITS'(1);
                            end
                        end else begin
                            col_q <= col_q + COL_BITS'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = (state == S_RUN);

    // Entry layout matches skid_entry_t: {tdata, tuser, tlast}.
    assign in_entry = {datain, sof, eol};

    axis_skid_buffer #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .allow     (run_next),
        .in_valid  (src_rdy_i),
        .in_data   (in_entry),
        .in_ready  (dst_rdy_o),
        .out_valid (m_tvalid),
        .out_data  (out_entry),
        .out_ready (m_tready)
    );

    assign m_tdata = out_entry[PAYLOAD_W-1:META_BITS];
    assign m_tuser = out_entry[1];
    assign m_tlast = out_entry[0];

`ifdef VIDEO_FRAMER_STATS_EN
    // Completed-frame counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= '0;
        end else if (clear) begin
            frame_count <= '0;
        end else if (frame_end) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    assign line_count = row_q;
`endif

endmodule
